// File: rtl/kf_channel_scheduler.sv
// rtl/kf_channel_scheduler.sv - round-robin sharing of one kalman_filter core between sensor channels
//
// Purpose:
//   Buffers one pending sample per channel, grants the filter core round-robin,
//   drives the core's start/done handshake and forwards each posterior, tagged
//   with its channel, over a valid/ready handshake.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   meas_valid, meas_data   per-channel sample strobe and data (channel c at [c*W +: W])
//   clear_flags             strobe clearing the sticky flags
//   kf_start, kf_ch, kf_z   request to the filter core (start pulse, state bank, measurement)
//   kf_done, kf_x           completion pulse and posterior from the filter core
//   out_valid, out_ready    result handshake towards parallel_2_serial
//   out_data, out_ch        posterior and its channel tag
//   overrun, timeout_err    sticky error flags
//   busy                    scheduler is not idle
module kf_channel_scheduler #(
  parameter int NUM_CH  = 3,
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         meas_valid,
  input  logic [NUM_CH*W-1:0]       meas_data,
  input  logic                      clear_flags,
  output logic                      kf_start,
  output logic [$clog2(NUM_CH)-1:0] kf_ch,
  output logic [W-1:0]              kf_z,
  input  logic                      kf_done,
  input  logic [W-1:0]              kf_x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [NUM_CH-1:0]         overrun,
  output logic                      timeout_err,
  output logic                      busy
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int CW  = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0]      hold [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [CHW-1:0]    rr_ptr;
  logic [CW-1:0]     wait_cnt;

  logic [CHW-1:0]    grant;
  logic [NUM_CH-1:0] grant_oh;
  logic [NUM_CH-1:0] overrun_set;
  logic              grant_fire;
  logic              wait_done;
  logic              wait_expire;
  logic              out_fire;

  // Channel reached by stepping 'off' places from 'base', wrapping at NUM_CH.
  function automatic logic [CHW-1:0] rr_idx(input logic [CHW-1:0] base, input int off);
    int unsigned s;
    s = 32'(base) + 32'(off);
    if (s >= NUM_CH) s = s - NUM_CH;
    return CHW'(s);
  endfunction

  // Scan from the far end back towards rr_ptr so the last hit is the first
  // pending channel at or after rr_ptr.
  always_comb begin
    grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[rr_idx(rr_ptr, i)]) grant = rr_idx(rr_ptr, i);
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_fire) grant_oh[grant] = 1'b1;
  end

  // A strobe into an already-pending slot overwrites it, unless that slot is
  // being granted this very cycle (the old sample leaves, the new one waits).
  assign overrun_set = meas_valid & pending & ~grant_oh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_fire  = 1'b0;
    wait_done   = 1'b0;
    wait_expire = 1'b0;
    out_fire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (|pending) begin
          grant_fire = 1'b1;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (kf_done) begin
          wait_done = 1'b1;
          state_nxt = S_OUTPUT;
        end else if (wait_cnt >= CNT_LAST) begin
          wait_expire = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_OUTPUT: begin
        if (out_valid && out_ready) begin
          out_fire  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign kf_start = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      overrun <= '0;
      for (int c = 0; c < NUM_CH; c++) hold[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (meas_valid[c]) begin
          hold[c]    <= meas_data[c*W +: W];
          pending[c] <= 1'b1;
        end else if (grant_oh[c]) begin
          pending[c] <= 1'b0;
        end
      end
      // A set in the same cycle as clear_flags survives the clear.
      overrun <= (clear_flags ? '0 : overrun) | overrun_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      kf_ch       <= '0;
      kf_z        <= '0;
      wait_cnt    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant_fire) begin
        kf_ch  <= grant;
        kf_z   <= hold[grant];
        rr_ptr <= (grant == CH_LAST) ? '0 : grant + 1'b1;
      end

      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT && !kf_done && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (wait_done) begin
        out_valid <= 1'b1;
        out_data  <= kf_x;
        out_ch    <= kf_ch;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      timeout_err <= (timeout_err && !clear_flags) || wait_expire;
    end
  end

endmodule

// File: tb/tb_kf_channel_scheduler.sv
// tb/tb_kf_channel_scheduler.sv - self-checking bench for kf_channel_scheduler
module tb_kf_channel_scheduler;

  localparam int NUM_CH  = 3;
  localparam int W       = 16;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              reset_n;
  logic [NUM_CH-1:0] meas_valid;
  logic [NUM_CH*W-1:0] meas_data;
  logic              clear_flags;
  logic              kf_start;
  logic [1:0]        kf_ch;
  logic [W-1:0]      kf_z;
  logic              kf_done;
  logic [W-1:0]      kf_x;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [1:0]        out_ch;
  logic [NUM_CH-1:0] overrun;
  logic              timeout_err;
  logic              busy;

  kf_channel_scheduler #(.NUM_CH(NUM_CH), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .meas_valid(meas_valid), .meas_data(meas_data), .clear_flags(clear_flags),
    .kf_start(kf_start), .kf_ch(kf_ch), .kf_z(kf_z),
    .kf_done(kf_done), .kf_x(kf_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .overrun(overrun), .timeout_err(timeout_err), .busy(busy)
  );

  typedef struct packed {
    logic [7:0]  ch;
    logic [15:0] v;
  } sb_t;

  typedef struct {
    int          ch;
    logic [15:0] z;
    logic [15:0] x;
  } vec_t;

  sb_t exp_issue[$];
  sb_t exp_out[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // written by the monitor
  int n_start     = 0;
  int start_cyc   = 0;
  int ov_rise_cyc = 0;
  int ov_count    = 0;
  // written by the core model
  int done_cyc    = 0;
  int poke_ack    = 0;
  // written by the test
  int strobe_cyc  = 0;
  int poke_req    = 0;
  logic core_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc_n++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  function automatic logic [15:0] xform(input logic [15:0] z);
    return {z[15:8], z[7:0] ^ 8'h34};
  endfunction

  // Filter core: answers 4 cycles after each start when enabled.
  initial begin
    int          core_cnt;
    logic [15:0] core_z;
    core_cnt = 0;
    core_z   = '0;
    kf_done  = 1'b0;
    kf_x     = '0;
    forever begin
      @(negedge clk);
      kf_done = 1'b0;
      if (core_cnt != 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          kf_done  = 1'b1;
          kf_x     = xform(core_z);
          done_cyc = cyc_n;
        end
      end else if (kf_start && core_en && reset_n) begin
        core_cnt = 4;
        core_z   = kf_z;
      end
      if (poke_req != poke_ack) begin
        kf_done  = 1'b1;
        kf_x     = 16'hDEAD;
        poke_ack = poke_req;
      end
    end
  end

  // Scoreboard monitor: pops expected issues on kf_start and expected results on handshakes.
  initial begin
    sb_t  it;
    logic ov_q;
    ov_q = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (kf_start) begin
          n_start++;
          start_cyc = cyc_n;
          check("issue_expected", 32'(exp_issue.size() != 0), 1);
          if (exp_issue.size() != 0) begin
            it = exp_issue.pop_front();
            check("issue_ch", 32'(kf_ch), 32'(it.ch));
            check("issue_z", 32'(kf_z), 32'(it.v));
          end
        end
        if (out_valid && !ov_q) ov_rise_cyc = cyc_n;
        if (out_valid) ov_count++;
        ov_q = out_valid;
        if (out_valid && out_ready) begin
          check("out_expected", 32'(exp_out.size() != 0), 1);
          if (exp_out.size() != 0) begin
            it = exp_out.pop_front();
            check("out_ch", 32'(out_ch), 32'(it.ch));
            check("out_data", 32'(out_data), 32'(it.v));
          end
        end
      end else begin
        ov_q = 1'b0;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int ch, input logic [15:0] z);
    cycle();
    meas_valid     = '0;
    meas_valid[ch] = 1'b1;
    meas_data[ch*W +: W] = z;
    strobe_cyc = cyc_n;
    cycle();
    meas_valid = '0;
  endtask

  task automatic expect_txn(input int ch, input logic [15:0] z, input logic [15:0] x);
    exp_issue.push_back('{ch: 8'(ch), v: z});
    exp_out.push_back('{ch: 8'(ch), v: x});
  endtask

  task automatic wait_idle(input string name);
    logic reached;
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (!busy && !out_valid && exp_issue.size() == 0 && exp_out.size() == 0) begin
        reached = 1'b1;
        break;
      end
    end
    check(name, 32'(reached), 1);
  endtask

  vec_t vecs [5];

  initial begin
    int   s0;
    int   ov0;
    logic seen;

    vecs[0] = '{1, 16'h1234, 16'h1200};
    vecs[1] = '{0, 16'h00FF, 16'h00CB};
    vecs[2] = '{2, 16'hBEEF, 16'hBEDB};
    vecs[3] = '{0, 16'h0034, 16'h0000};
    vecs[4] = '{2, 16'hFFFF, 16'hFFCB};

    reset_n     = 1'b0;
    meas_valid  = '0;
    meas_data   = '0;
    clear_flags = 1'b0;
    out_ready   = 1'b1;
    core_en     = 1'b1;

    repeat (3) cycle();
    check("rst_kf_start", 32'(kf_start), 0);
    check("rst_kf_ch", 32'(kf_ch), 0);
    check("rst_kf_z", 32'(kf_z), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    repeat (2) cycle();

    // single-sample transactions with latency checks
    for (int i = 0; i < 5; i++) begin
      expect_txn(vecs[i].ch, vecs[i].z, vecs[i].x);
      strobe(vecs[i].ch, vecs[i].z);
      wait_idle("vec_idle");
      check("vec_start_latency", 32'(start_cyc - strobe_cyc), 2);
      check("vec_out_latency", 32'(ov_rise_cyc - done_cyc), 1);
    end

    // round-robin over all three channels strobed together
    expect_txn(0, 16'hA000, 16'hA034);
    expect_txn(1, 16'hB000, 16'hB034);
    expect_txn(2, 16'hC000, 16'hC034);
    cycle();
    meas_valid = 3'b111;
    meas_data  = {16'hC000, 16'hB000, 16'hA000};
    cycle();
    meas_valid = '0;
    wait_idle("rr_idle");
    check("rr_overrun", 32'(overrun), 0);

    // backpressure and overrun
    out_ready = 1'b0;
    expect_txn(0, 16'h1111, 16'h1125);
    strobe(0, 16'h1111);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_out_valid_seen", 32'(seen), 1);
    s0 = n_start;
    strobe(2, 16'h0001);
    strobe(2, 16'h0002);
    repeat (3) cycle();
    check("bp_overrun", 32'(overrun), 32'h4);
    check("bp_hold_valid", 32'(out_valid), 1);
    check("bp_hold_data", 32'(out_data), 32'h1125);
    check("bp_hold_ch", 32'(out_ch), 0);
    check("bp_no_grant", 32'(n_start - s0), 0);
    exp_issue.push_back('{ch: 8'd2, v: 16'h0002});
    exp_out.push_back('{ch: 8'd2, v: 16'h0036});
    out_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_overrun_sticky", 32'(overrun), 32'h4);
    clear_flags = 1'b1;
    cycle();
    clear_flags = 1'b0;
    check("bp_overrun_cleared", 32'(overrun), 0);

    // strobe into the channel being granted in the same cycle
    expect_txn(0, 16'h4444, 16'h4470);
    expect_txn(0, 16'h5555, 16'h5561);
    cycle();
    meas_valid = 3'b001;
    meas_data[15:0] = 16'h4444;
    cycle();
    check("same_grant_cycle_idle", 32'(busy), 0);
    meas_data[15:0] = 16'h5555;
    cycle();
    meas_valid = '0;
    wait_idle("same_idle");
    check("same_overrun", 32'(overrun), 0);

    // timeout with the core withheld, then a late done
    core_en = 1'b0;
    exp_issue.push_back('{ch: 8'd1, v: 16'h7777});
    ov0 = ov_count;
    strobe(1, 16'h7777);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (timeout_err) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_flag_seen", 32'(seen), 1);
    check("to_cycle", 32'(cyc_n - start_cyc), 9);
    check("to_busy", 32'(busy), 0);
    poke_req++;
    repeat (3) cycle();
    check("to_late_done_err", 32'(timeout_err), 1);
    check("to_late_done_busy", 32'(busy), 0);
    check("to_no_output", 32'(ov_count - ov0), 0);
    clear_flags = 1'b1;
    cycle();
    clear_flags = 1'b0;
    check("to_cleared", 32'(timeout_err), 0);

    // asynchronous reset during WAIT
    exp_issue.push_back('{ch: 8'd2, v: 16'h9999});
    strobe(2, 16'h9999);
    repeat (3) cycle();
    check("rw_in_wait", 32'(busy), 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("rw_busy", 32'(busy), 0);
    check("rw_kf_ch", 32'(kf_ch), 0);
    check("rw_kf_z", 32'(kf_z), 0);
    check("rw_kf_start", 32'(kf_start), 0);
    check("rw_out_valid", 32'(out_valid), 0);
    cycle();
    reset_n = 1'b1;
    core_en = 1'b1;
    s0 = n_start;
    repeat (10) cycle();
    check("rw_no_start", 32'(n_start - s0), 0);
    expect_txn(0, 16'hA5A5, 16'hA591);
    strobe(0, 16'hA5A5);
    wait_idle("rw_idle");

    check("final_issue_q", 32'(exp_issue.size()), 0);
    check("final_out_q", 32'(exp_out.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kf_channel_scheduler.md
Name: kf_channel_scheduler

Overview:
- Shares one kalman_filter core between NUM_CH sensor axes. Each axis delivers 16-bit big-endian samples that have already been deserialized and brought into the system clock domain.
- Holds one pending sample per channel, grants the core round-robin and drives the core's start/done handshake.
- Hands each posterior, tagged with its channel index, to the parallel_2_serial path over a valid/ready handshake.
- Sits between the serial_2_parallel stage and the kalman_filter/parallel_2_serial stages in top.

Parameters:
- NUM_CH, 3, number of sensor channels sharing the filter core (2..8).
- W, 16, sample and posterior width in bits.
- TIMEOUT, 255, maximum cycles in WAIT before the core is abandoned (1..65535).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- meas_valid  in  NUM_CH  per-channel single-cycle sample strobe.
- meas_data  in  NUM_CH*W  channel c occupies bits [c*W +: W].
- clear_flags  in  1  single-cycle strobe that clears all sticky flags.
- kf_start  out  1  single-cycle start pulse to the filter core.
- kf_ch  out  clog2(NUM_CH)  channel selected for the core's state bank; stable from ISSUE until the scheduler leaves WAIT.
- kf_z  out  W  measurement for the core; stable from ISSUE until the scheduler leaves WAIT.
- kf_done  in  1  single-cycle completion pulse from the core.
- kf_x  in  W  posterior; valid in the cycle kf_done is high.
- out_valid  out  1  a result is available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  posterior.
- out_ch  out  clog2(NUM_CH)  channel tag for out_data.
- overrun  out  NUM_CH  sticky; a pending sample was overwritten.
- timeout_err  out  1  sticky; the core failed to respond within TIMEOUT cycles.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: state=IDLE, pending=0, rr_ptr=0. All outputs are 0: kf_start, kf_ch, kf_z, out_valid, out_data, out_ch, overrun, timeout_err, busy.
- Pending buffer:
  - meas_valid[c] loads hold[c]=data and sets pending[c].
  - If pending[c] is already set and c is not being granted in the same cycle, the new sample overwrites hold[c] and overrun[c] is set.
  - If c is granted in the same cycle as meas_valid[c], the new sample becomes pending and no overrun is flagged.
- Arbitration: round-robin. Search begins at rr_ptr and wraps at NUM_CH-1 back to 0. After a grant, rr_ptr = granted+1, mod NUM_CH.
- State machine:
  - IDLE: if pending is non-zero, latch kf_ch=grant and kf_z=hold[grant], clear pending[grant], go to ISSUE. If pending is zero, stay in IDLE.
  - ISSUE: kf_start=1 for exactly this cycle, clear the timeout counter, go to WAIT.
  - WAIT, on kf_done: out_data<=kf_x, out_ch<=kf_ch, out_valid<=1, go to OUTPUT.
  - WAIT, no kf_done: increment the counter. When the counter reaches TIMEOUT, set timeout_err, go to IDLE, no output is produced and the sample is dropped.
  - OUTPUT: hold out_valid, out_data and out_ch stable until out_valid&&out_ready. On that cycle clear out_valid and go to IDLE.
- Latency: pending in IDLE at cycle t → kf_start at t+1. kf_done at cycle d → out_valid at d+1. Handshake at cycle h → back in IDLE at h+1, so a next grant can issue kf_start at h+2.
- Backpressure: there is no new grant while in OUTPUT. Samples keep accumulating in the hold registers, with overrun flagged as above.
- kf_done is ignored outside WAIT, and flags nothing.
- clear_flags zeroes overrun and timeout_err. If a set event lands in the same cycle, the set wins.
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.
- Reset mid-operation: asynchronous return to the reset values. Pending samples and any in-flight result are discarded.

Test Plan:
- Single sample: NUM_CH=3, meas_valid=3'b010, data 0x1234 at cycle 0 → kf_start at cycle 2 with kf_ch=1, kf_z=0x1234. kf_done with kf_x=0x1200 → next cycle out_valid=1, out_data=0x1200, out_ch=1. out_ready=1 completes the handshake.
- Round-robin: all three channels strobed in one cycle (0xA000, 0xB000, 0xC000), core answers 4 cycles after each start, out_ready tied high → grants in order ch0, ch1, ch2; out_ch sequence 0,1,2; overrun=0.
- Overrun and backpressure: hold out_ready=0 with a result in OUTPUT, then strobe ch2 twice (0x0001, then 0x0002) → overrun=3'b100; after release, the ch2 issue carries kf_z=0x0002. clear_flags → overrun=0.
- Same-cycle grant and strobe: ch0 pending in IDLE, meas_valid[0]=1 with 0x5555 in the grant cycle → no overrun; 0x5555 is pending and issues after the current transaction.
- Timeout: TIMEOUT=8, kf_done withheld → timeout_err=1 after 8 WAIT cycles, state back to IDLE, out_valid never asserted. A late kf_done is ignored.
- Reset: assert reset_n=0 during WAIT → all outputs 0 asynchronously. After release, no kf_start occurs until a new meas_valid arrives.
